// File: rtl/cache_mem_pkg.sv
//------------------------------------------------------------------------------
// Module : cache_mem_pkg
// Brief  : Shared types and default geometry for the cache backing memory.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package cache_mem_pkg;

    localparam int DEF_DATA_WIDTH  = 32;
    localparam int DEF_ADDR_WIDTH  = 32;
    localparam int DEF_DEPTH_WORDS = 1024;
    localparam int DEF_LINE_WORDS  = 4;
    localparam int DEF_LATENCY     = 3;

    localparam int OFFSET_BITS   = $clog2(DEF_LINE_WORDS) + 2;
    localparam int WORD_IDX_BITS = $clog2(DEF_DEPTH_WORDS);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WAIT   = 3'd1,
        ST_RBURST = 3'd2,
        ST_WBURST = 3'd3,
        ST_DONE   = 3'd4
    } mem_state_t;

    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_word_array.sv
//------------------------------------------------------------------------------
// Module : mem_word_array
// Brief  : Single-port word storage, synchronous write, registered read.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mem_word_array #(
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int IDX_W       = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_we,
    input  logic [IDX_W-1:0]      i_addr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    // Storage is deliberately not reset so contents survive a reset pulse.
    logic [DATA_WIDTH-1:0] r_mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_rdata <= '0;
        end else begin
            o_rdata <= r_mem[i_addr];
        end
    end

endmodule

`default_nettype wire

// File: rtl/cache_backing_mem.sv
//------------------------------------------------------------------------------
// Module : cache_backing_mem
// Brief  : Fixed-latency line-burst memory responder for cache refill/writeback.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module cache_backing_mem
    import cache_mem_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int DEPTH_WORDS = DEF_DEPTH_WORDS,
    parameter int LINE_WORDS  = DEF_LINE_WORDS,
    parameter int LATENCY     = DEF_LATENCY
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_req,
    input  logic                  mem_we,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_ready,
    input  logic                  mem_wvalid,
    input  logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_wready,
    output logic                  mem_wdone,
    output logic                  mem_rvalid,
    output logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  mem_rlast
);

    localparam int c_CNT_W  = $clog2(LINE_WORDS);
    localparam int c_IDX_W  = $clog2(DEPTH_WORDS);
    localparam int c_OFF_W  = c_CNT_W + 2;
    localparam int c_LINE_W = c_IDX_W - c_CNT_W;
    localparam int c_LAT_W  = clog2_min1(LATENCY);

    localparam logic [c_CNT_W-1:0] c_BEAT_LAST = c_CNT_W'(LINE_WORDS - 1);
    localparam logic [c_LAT_W-1:0] c_LAT_LAST  = c_LAT_W'(LATENCY - 1);

    mem_state_t            r_state;
    logic [c_LINE_W-1:0]   r_line;
    logic                  r_we;
    logic [c_LAT_W-1:0]    r_lat;
    logic [c_CNT_W-1:0]    r_cnt;

    logic [c_LINE_W-1:0]   w_req_line;
    logic [c_CNT_W-1:0]    w_rd_off;
    logic [c_IDX_W-1:0]    w_arr_addr;
    logic                  w_arr_we;
    logic                  w_unused;

    // Line index taken modulo the storage depth; offset bits dropped.
    assign w_req_line = mem_addr[c_OFF_W +: c_LINE_W];
    assign w_unused   = ^mem_addr;

    // Read address runs one beat ahead so the registered read lines up with rvalid.
    assign w_rd_off   = (r_state == ST_RBURST) ? r_cnt + 1'b1 : '0;
    assign w_arr_addr = {r_line, (r_state == ST_WBURST) ? r_cnt : w_rd_off};
    assign w_arr_we   = (r_state == ST_WBURST) && mem_wvalid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_line     <= '0;
            r_we       <= 1'b0;
            r_lat      <= '0;
            r_cnt      <= '0;
            mem_ready  <= 1'b0;
            mem_wready <= 1'b0;
            mem_wdone  <= 1'b0;
            mem_rvalid <= 1'b0;
            mem_rlast  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    mem_ready <= 1'b1;
                    if (mem_req && mem_ready) begin
                        r_line    <= w_req_line;
                        r_we      <= mem_we;
                        r_lat     <= '0;
                        mem_ready <= 1'b0;
                        r_state   <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (r_lat == c_LAT_LAST) begin
                        r_cnt <= '0;
                        if (r_we) begin
                            mem_wready <= 1'b1;
                            r_state    <= ST_WBURST;
                        end else begin
                            mem_rvalid <= 1'b1;
                            mem_rlast  <= (LINE_WORDS == 1);
                            r_state    <= ST_RBURST;
                        end
                    end else begin
                        r_lat <= r_lat + 1'b1;
                    end
                end
                ST_RBURST: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == c_BEAT_LAST) begin
                        mem_rvalid <= 1'b0;
                        mem_rlast  <= 1'b0;
                        mem_ready  <= 1'b1;
                        r_state    <= ST_IDLE;
                    end else begin
                        mem_rlast <= (r_cnt == c_BEAT_LAST - 1'b1);
                    end
                end
                ST_WBURST: begin
                    if (mem_wvalid) begin
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == c_BEAT_LAST) begin
                            mem_wready <= 1'b0;
                            mem_wdone  <= 1'b1;
                            r_state    <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    mem_wdone <= 1'b0;
                    mem_ready <= 1'b1;
                    r_state   <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    mem_word_array #(
        .DATA_WIDTH  (DATA_WIDTH),
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (c_IDX_W)
    ) u_array (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_arr_we),
        .i_addr  (w_arr_addr),
        .i_wdata (mem_wdata),
        .o_rdata (mem_rdata)
    );

endmodule

`default_nettype wire

// File: tb/tb_cache_backing_mem.sv
//------------------------------------------------------------------------------
// Module : tb_cache_backing_mem
// Brief  : Scoreboard bench for cache_backing_mem refill/writeback bursts.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_cache_backing_mem;

    localparam int DW    = 32;
    localparam int AW    = 32;
    localparam int DEPTH = 1024;
    localparam int LW    = 4;
    localparam int LAT   = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic          mem_ready;
    logic          mem_wvalid;
    logic [DW-1:0] mem_wdata;
    logic          mem_wready;
    logic          mem_wdone;
    logic          mem_rvalid;
    logic [DW-1:0] mem_rdata;
    logic          mem_rlast;

    always #5 clk = ~clk;

    cache_backing_mem #(
        .DATA_WIDTH  (DW),
        .ADDR_WIDTH  (AW),
        .DEPTH_WORDS (DEPTH),
        .LINE_WORDS  (LW),
        .LATENCY     (LAT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_ready  (mem_ready),
        .mem_wvalid (mem_wvalid),
        .mem_wdata  (mem_wdata),
        .mem_wready (mem_wready),
        .mem_wdone  (mem_wdone),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .mem_rlast  (mem_rlast)
    );

    logic [DW-1:0] exp_data_q[$];
    logic          exp_last_q[$];
    int            wdone_pending = 0;
    int            nchk = 0;
    int            nerr = 0;
    logic [DW-1:0] m_d;
    logic          m_l;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a beat or wdone.
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_rvalid) begin
                if (exp_data_q.size() == 0) begin
                    check("unexpected_rbeat", 32'(mem_rvalid), 32'd0);
                end else begin
                    m_d = exp_data_q.pop_front();
                    m_l = exp_last_q.pop_front();
                    check("rdata", mem_rdata, m_d);
                    check("rlast", 32'(mem_rlast), 32'(m_l));
                end
            end
            if (mem_wdone) begin
                check("wdone_expected", 32'(wdone_pending > 0), 32'd1);
                if (wdone_pending > 0) wdone_pending--;
            end
        end
    end

    task automatic do_req(input logic [31:0] addr, input logic we);
        int n;
        n = 0;
        while (!mem_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("ready_before_req", 32'(mem_ready), 32'd1);
        mem_req  = 1'b1;
        mem_we   = we;
        mem_addr = addr;
        @(posedge clk);
        #1;
        mem_req  = 1'b0;
        mem_we   = 1'($urandom);
        mem_addr = $urandom;
    endtask

    task automatic refill(input logic [31:0] addr, input logic [31:0] base,
                          input bit busy, input bit rst_mid);
        int n;
        for (int i = 0; i < LW; i++) begin
            exp_data_q.push_back(base + 32'(i));
            exp_last_q.push_back(i == LW - 1);
        end
        do_req(addr, 1'b0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!mem_rvalid && n < 20);
        check("read_latency", 32'(n), 32'(LAT + 1));
        if (busy) begin
            mem_req  = 1'b1;
            mem_we   = 1'b0;
            mem_addr = 32'h0000_00C0;
            @(negedge clk);
            @(negedge clk);
            mem_req  = 1'b0;
        end
        if (rst_mid) begin
            @(negedge clk);
            #1;
            rst = 1'b1;
            #1;
            check("rst_rvalid", 32'(mem_rvalid), 32'd0);
            check("rst_rlast",  32'(mem_rlast),  32'd0);
            check("rst_ready",  32'(mem_ready),  32'd0);
            check("rst_wready", 32'(mem_wready), 32'd0);
            check("rst_rdata",  mem_rdata,       32'd0);
            exp_data_q.delete();
            exp_last_q.delete();
            @(posedge clk);
            @(negedge clk);
            rst = 1'b0;
            @(posedge clk);
            #1;
            check("ready_after_rst", 32'(mem_ready), 32'd1);
        end else begin
            n = 0;
            while (mem_rvalid && n < 20) begin
                @(negedge clk);
                n++;
            end
            check("rburst_len", 32'(n), busy ? 32'(LW - 2) : 32'(LW));
            check("ready_after_read", 32'(mem_ready), 32'd1);
        end
    endtask

    task automatic writeback(input logic [31:0] addr, input logic [31:0] base, input bit stall);
        int n;
        wdone_pending++;
        do_req(addr, 1'b1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!mem_wready && n < 20);
        check("write_latency", 32'(n), 32'(LAT + 1));
        for (int i = 0; i < LW; i++) begin
            mem_wvalid = 1'b1;
            mem_wdata  = base + 32'(i);
            @(posedge clk);
            #1;
            mem_wvalid = 1'b0;
            mem_wdata  = $urandom;
            if (stall && i == 1) begin
                repeat (2) begin
                    @(negedge clk);
                    check("wready_stall", 32'(mem_wready), 32'd1);
                    @(posedge clk);
                    #1;
                end
            end
        end
        @(negedge clk);
        check("wdone_pulse", 32'(mem_wdone), 32'd1);
        check("ready_in_done", 32'(mem_ready), 32'd0);
        check("wready_off", 32'(mem_wready), 32'd0);
        @(negedge clk);
        check("wdone_single", 32'(mem_wdone), 32'd0);
        check("ready_after_write", 32'(mem_ready), 32'd1);
    endtask

    initial begin
        rst        = 1'b1;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wvalid = 1'b0;
        mem_wdata  = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_ready",  32'(mem_ready),  32'd0);
        check("reset_rvalid", 32'(mem_rvalid), 32'd0);
        check("reset_wready", 32'(mem_wready), 32'd0);
        check("reset_wdone",  32'(mem_wdone),  32'd0);
        check("reset_rlast",  32'(mem_rlast),  32'd0);
        check("reset_rdata",  mem_rdata,       32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("ready_first_edge", 32'(mem_ready), 32'd1);

        writeback(32'h0000_0040, 32'hAAAA_5555, 1'b0);
        refill   (32'h0000_0040, 32'hAAAA_5555, 1'b0, 1'b0);
        refill   (32'h0000_004C, 32'hAAAA_5555, 1'b0, 1'b0);
        writeback(32'h0000_0080, 32'hCCCC_7777, 1'b0);
        refill   (32'h0000_0080, 32'hCCCC_7777, 1'b0, 1'b0);
        refill   (32'h0000_0040, 32'hAAAA_5555, 1'b0, 1'b0);
        writeback(32'h0000_0100, 32'h1111_0000, 1'b1);
        refill   (32'h0000_0100, 32'h1111_0000, 1'b0, 1'b0);
        refill   (32'h0000_0040, 32'hAAAA_5555, 1'b1, 1'b0);
        refill   (32'h0000_0080, 32'hCCCC_7777, 1'b0, 1'b0);
        refill   (32'h0000_0080, 32'hCCCC_7777, 1'b0, 1'b1);
        refill   (32'h0000_0080, 32'hCCCC_7777, 1'b0, 1'b0);
        // Address beyond storage wraps back onto line 0x40.
        refill   (32'h0000_1040, 32'hAAAA_5555, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 32'(exp_data_q.size()), 32'd0);
        check("wdone_outstanding", 32'(wdone_pending), 32'd0);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, checks=%0d", nchk);
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
